img_bool_packer: RTL and testbench

- Upstream feeder for the classifier top level. Accepts a byte-per-pixel grayscale AXI-Stream and booleanizes each pixel against a programmable threshold.
- Packs the resulting bits row-major into 128-bit AXI-Stream beats, which drive the classifier's tdata/tvalid/tready/tkeep/tlast image load port.
- Enforces fixed framing of ceil(HEIGHT*WIDTH/128) beats per image, whatever the input tlast does.

---
 rtl/img_bool_packer.sv | 162 ++++++++++++++++
 tb/tb_img_bool_packer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_bool_packer.sv
// Booleanizes a byte-per-pixel grayscale stream against a per-image threshold and
// packs the bits row-major into fixed-count OUT_W-bit AXI-Stream beats.
module img_bool_packer #(
    parameter int HEIGHT = 28,
    parameter int WIDTH  = 28,
    parameter int OUT_W  = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         threshold,
    input  logic [7:0]         s_tdata,
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic               s_tlast,
    output logic [OUT_W-1:0]   m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic [OUT_W/8-1:0] m_tkeep,
    output logic               m_tlast,
    output logic [15:0]        img_count,
    output logic               err_len
);

    localparam int NPIX       = HEIGHT * WIDTH;
    localparam int BEATS      = (NPIX + OUT_W - 1) / OUT_W;
    localparam int KW         = OUT_W / 8;
    localparam int PIX_W      = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int BIT_W      = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAST_BYTES = (NPIX - (BEATS - 1) * OUT_W + 7) / 8;
    localparam logic [KW-1:0] KEEP_LAST = {KW{1'b1}} >> (KW - LAST_BYTES);

    typedef enum logic {
        S_ACCEPT,
        S_PAD
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PIX_W-1:0]  r_pix_idx;
    logic [BIT_W-1:0]  r_bit_pos;
    logic [BEAT_W-1:0] r_beat_idx;
    logic [OUT_W-1:0]  r_acc;
    logic [7:0]        r_thr;
    logic [OUT_W-1:0]  r_m_tdata;
    logic [KW-1:0]     r_m_tkeep;
    logic              r_m_tvalid;
    logic              r_m_tlast;
    logic [15:0]       r_img_count;
    logic              r_err_len;

    logic              w_out_free;
    logic              w_last_pix;
    logic              w_beat_full;
    logic              w_last_beat;
    logic              w_closes;
    logic              w_early;
    logic              w_s_tready;
    logic              w_accept;
    logic [7:0]        w_thr;
    logic              w_pix_bit;
    logic              w_load;
    logic [OUT_W-1:0]  w_beat_data;
    logic [OUT_W-1:0]  w_load_data;

    assign w_out_free  = !r_m_tvalid || m_tready;
    assign w_last_pix  = (r_pix_idx == PIX_W'(NPIX - 1));
    assign w_beat_full = (r_bit_pos == BIT_W'(OUT_W - 1));
    assign w_last_beat = (r_beat_idx == BEAT_W'(BEATS - 1));
    // Any pixel that closes a beat needs the output register; others never stall.
    assign w_closes    = w_beat_full || w_last_pix || s_tlast;
    assign w_early     = s_tlast && !w_last_pix;
    assign w_s_tready  = !rst && (r_state == S_ACCEPT) && (!w_closes || w_out_free);
    assign w_accept    = s_tvalid && w_s_tready;
    assign w_thr       = (r_pix_idx == '0) ? threshold : r_thr;
    assign w_pix_bit   = (s_tdata >= w_thr);
    assign w_load      = (w_accept && w_closes) || ((r_state == S_PAD) && w_out_free);
    assign w_load_data = (r_state == S_PAD) ? '0 : w_beat_data;

    always_comb begin
        w_beat_data            = r_acc;
        w_beat_data[r_bit_pos] = w_pix_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_ACCEPT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ACCEPT: if (w_accept && w_early && !w_last_beat) w_state_nxt = S_PAD;
            S_PAD:    if (w_out_free && w_last_beat) w_state_nxt = S_ACCEPT;
            default:  w_state_nxt = S_ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_idx   <= '0;
            r_bit_pos   <= '0;
            r_beat_idx  <= '0;
            r_acc       <= '0;
            r_thr       <= '0;
            r_m_tdata   <= '0;
            r_m_tkeep   <= '0;
            r_m_tvalid  <= 1'b0;
            r_m_tlast   <= 1'b0;
            r_img_count <= '0;
            r_err_len   <= 1'b0;
        end else begin
            r_err_len <= w_accept && (w_early || (w_last_pix && !s_tlast));
            if (w_accept && (r_pix_idx == '0)) r_thr <= threshold;

            if (w_load) begin
                r_m_tdata  <= w_load_data;
                r_m_tkeep  <= w_last_beat ? KEEP_LAST : {KW{1'b1}};
                r_m_tlast  <= w_last_beat;
                r_m_tvalid <= 1'b1;
            end else if (m_tready) begin
                r_m_tvalid <= 1'b0;
            end

            if (r_m_tvalid && m_tready && r_m_tlast) r_img_count <= r_img_count + 16'd1;

            if (w_accept) begin
                if (!w_closes) begin
                    r_acc     <= w_beat_data;
                    r_bit_pos <= r_bit_pos + BIT_W'(1);
                    r_pix_idx <= r_pix_idx + PIX_W'(1);
                end else begin
                    r_acc     <= '0;
                    r_bit_pos <= '0;
                    // An early tlast inside the final beat ends the image with no padding.
                    if (w_last_pix || w_last_beat) begin
                        r_pix_idx  <= '0;
                        r_beat_idx <= '0;
                    end else if (w_early) begin
                        r_pix_idx  <= '0;
                        r_beat_idx <= r_beat_idx + BEAT_W'(1);
                    end else begin
                        r_pix_idx  <= r_pix_idx + PIX_W'(1);
                        r_beat_idx <= r_beat_idx + BEAT_W'(1);
                    end
                end
            end else if ((r_state == S_PAD) && w_out_free) begin
                r_beat_idx <= w_last_beat ? '0 : r_beat_idx + BEAT_W'(1);
            end
        end
    end

    assign s_tready  = w_s_tready;
    assign m_tdata   = r_m_tdata;
    assign m_tkeep   = r_m_tkeep;
    assign m_tvalid  = r_m_tvalid;
    assign m_tlast   = r_m_tlast;
    assign img_count = r_img_count;
    assign err_len   = r_err_len;

endmodule

// File: tb/tb_img_bool_packer.sv
// Scoreboard bench for img_bool_packer: random pixels and back-pressure, expected
// beats computed from the pixel-to-bit mapping rules.
module tb_img_bool_packer;

    localparam int HEIGHT = 28;
    localparam int WIDTH  = 28;
    localparam int OUT_W  = 128;
    localparam int NPIX   = HEIGHT * WIDTH;
    localparam int BEATS  = (NPIX + OUT_W - 1) / OUT_W;
    localparam int KW     = OUT_W / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        threshold = 8'd128;
    logic [7:0]        s_tdata = '0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic              s_tlast = 1'b0;
    logic [OUT_W-1:0]  m_tdata;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic [KW-1:0]     m_tkeep;
    logic              m_tlast;
    logic [15:0]       img_count;
    logic              err_len;

    img_bool_packer #(.HEIGHT(HEIGHT), .WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .threshold(threshold),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast), .img_count(img_count), .err_len(err_len)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [KW-1:0]    keep;
        logic             last;
    } beat_t;

    beat_t      exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         err_seen = 0;
    int         err_base = 0;
    int         exp_err = 0;
    int         exp_img = 0;
    int         tready_mode = 0;
    int         tr_phase = 0;
    bit         gap_en = 0;
    bit         pad_mode = 0;
    logic [7:0] pix [NPIX];

    // Output back-pressure: 0 = always ready, 1 = 1-0-0-1 pattern, 2 = random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                0: m_tready = 1'b1;
                1: begin
                    m_tready = (tr_phase == 0) || (tr_phase == 3);
                    tr_phase = (tr_phase + 1) % 4;
                end
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge clk);
            if (err_len) err_seen++;
            if (!rst && m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat data=%h keep=%h last=%b", m_tdata, m_tkeep, m_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (m_tdata !== e.data || m_tkeep !== e.keep || m_tlast !== e.last) begin
                        errors++;
                        $display("FAIL beat got data=%h keep=%h last=%b want data=%h keep=%h last=%b",
                                 m_tdata, m_tkeep, m_tlast, e.data, e.keep, e.last);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Reference: pixel n maps to bit n%OUT_W of beat n/OUT_W; pixels after last_n read as 0.
    task automatic push_image(input int last_n, input logic [7:0] thr, input int nbeats);
        beat_t e;
        int n;
        for (int b = 0; b < nbeats; b++) begin
            e = '0;
            for (int k = 0; k < OUT_W; k++) begin
                n = b * OUT_W + k;
                if (n < NPIX && n <= last_n && pix[n] >= thr) e.data[k] = 1'b1;
            end
            for (int j = 0; j < KW; j++)
                if (j * 8 < NPIX - b * OUT_W) e.keep[j] = 1'b1;
            e.last = (b == BEATS - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_pixel(input int n, input bit last, input logic [7:0] thr);
        bit completing;
        if (gap_en) repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        s_tvalid   = 1'b1;
        s_tdata    = pix[n];
        s_tlast    = last;
        threshold  = thr;
        completing = (n % OUT_W == OUT_W - 1) || (n == NPIX - 1) || last;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (s_tready) begin
                @(posedge clk);
                #1;
                break;
            end
            if (!pad_mode) begin
                checks++;
                if (!completing || !(m_tvalid && !m_tready)) begin
                    errors++;
                    $display("FAIL stall pix=%0d s_tready=%b completing=%b m_tvalid=%b m_tready=%b",
                             n, s_tready, completing, m_tvalid, m_tready);
                end
            end
            if (t > 2000) begin
                errors++;
                $display("FAIL s_tready_timeout pix=%0d got=0 want=1", n);
                break;
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        pad_mode = last && (n != NPIX - 1);
    endtask

    // nsend pixels; tlast_at < 0 means no tlast; threshold switches to thr_b at change_at.
    task automatic send_image(input int nsend, input int tlast_at, input logic [7:0] thr_a,
                              input int change_at, input logic [7:0] thr_b, input int nbeats);
        push_image((tlast_at >= 0) ? tlast_at : NPIX - 1, thr_a, nbeats);
        for (int n = 0; n < nsend; n++)
            send_pixel(n, n == tlast_at, (n >= change_at) ? thr_b : thr_a);
    endtask

    task automatic fill_alt();
        for (int n = 0; n < NPIX; n++) pix[n] = (n % 2 != 0) ? 8'd200 : 8'd50;
    endtask

    task automatic fill_rand();
        for (int n = 0; n < NPIX; n++) pix[n] = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_drain();
        for (int t = 0; exp_q.size() != 0 && t < 5000; t++) @(posedge clk);
        chk("drain_remaining", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic finish_test();
        wait_drain();
        chk("img_count", 32'(img_count), 32'(exp_img));
        chk("err_len_pulses", 32'(err_seen - err_base), 32'(exp_err));
        err_base = err_seen;
        exp_err  = 0;
    endtask

    initial begin : stim
        int p;
        logic [7:0] thr;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata_nz", 32'(|m_tdata), 32'd0);
        chk("rst_m_tkeep", 32'(m_tkeep), 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_img_count", 32'(img_count), 32'd0);
        chk("rst_err_len", 32'(err_len), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Alternating pattern, always ready, then 1-0-0-1 back-pressure.
        fill_alt();
        send_image(NPIX, NPIX - 1, 8'd128, NPIX, 8'd128, BEATS);
        exp_img = 1;
        finish_test();
        tready_mode = 1;
        send_image(NPIX, NPIX - 1, 8'd128, NPIX, 8'd128, BEATS);
        exp_img = 2;
        finish_test();

        // Early tlast at pixel 300, then a normal image.
        tready_mode = 2;
        gap_en = 1;
        fill_rand();
        send_image(301, 300, 8'd128, NPIX, 8'd128, BEATS);
        exp_img = 3;
        exp_err = 1;
        finish_test();
        fill_rand();
        send_image(NPIX, NPIX - 1, 8'd90, NPIX, 8'd90, BEATS);
        exp_img = 4;
        finish_test();

        // Missing tlast followed by a second image.
        fill_rand();
        send_image(NPIX, -1, 8'd128, NPIX, 8'd128, BEATS);
        fill_rand();
        send_image(NPIX, NPIX - 1, 8'd60, NPIX, 8'd60, BEATS);
        exp_img = 6;
        exp_err = 1;
        finish_test();

        // Threshold change mid-image applies only to the next image.
        fill_rand();
        send_image(NPIX, NPIX - 1, 8'd128, 400, 8'd0, BEATS);
        fill_rand();
        send_image(NPIX, NPIX - 1, 8'd0, NPIX, 8'd0, BEATS);
        exp_img = 8;
        finish_test();

        // Random images, some ending early.
        for (int i = 0; i < 3; i++) begin
            fill_rand();
            thr = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                p = $urandom_range(0, NPIX - 2);
                send_image(p + 1, p, thr, NPIX, thr, BEATS);
                exp_err = exp_err + 1;
            end else begin
                send_image(NPIX, NPIX - 1, thr, NPIX, thr, BEATS);
            end
            exp_img = exp_img + 1;
        end
        finish_test();

        // Reset after 500 pixels; beats 0-2 are out, beat 3 is discarded.
        tready_mode = 0;
        gap_en = 0;
        fill_rand();
        send_image(500, -1, 8'd128, NPIX, 8'd128, 3);
        wait_drain();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_s_tready", 32'(s_tready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_mid_img_count", 32'(img_count), 32'd0);
        @(posedge clk);
        #1;
        err_base = err_seen;
        exp_img = 1;
        fill_rand();
        send_image(NPIX, NPIX - 1, 8'd100, NPIX, 8'd100, BEATS);
        finish_test();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
